uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among several byte producers (debug monitor, register-readback, echo path, and so on). Each requester owns a one-byte holding slot with a valid/ready handshake. The arbiter picks one full slot at a time and issues it to the transmitter with a single-tick start pulse. It then tracks the transmitter's busy flag and enforces an inter-frame idle gap. It runs in the baudclk domain, the same 16x-oversampled tick that drives the receiver.

## Interface
- NREQ, 4: number of requesters, 2..8.
- GAP_TICKS, 16: idle baudclk ticks after each frame before the next grant; minimum 1.
- ACK_TIMEOUT, 8: baudclk ticks to wait for tx_busy to rise after tx_start.
- baudclk  in  1  clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  requester i's byte in bits [8i+7:8i].
- req_ready  out  NREQ  slot i empty; registered.
- tx_data  out  8  byte to the transmitter.
- tx_start  out  1  one-tick start pulse.
- tx_busy  in  1  transmitter frame in progress.
- grant  out  NREQ  one-hot owner of the current frame; all zero when idle.
- tx_err  out  1  one-tick pulse when ACK_TIMEOUT expires.
- sent_cnt  out  16  completed frames; wraps at 0xFFFF.

## Operation
- Holding slots:
  - Slot i accepts a byte on req_valid[i] && req_ready[i] at a baudclk edge.
  - req_ready[i] falls after that edge.
  - Slot i frees on the edge that issues it; req_ready[i] rises after that edge.
  - A slot never accepts and issues on the same edge.
- States:
  - IDLE:
    - If any slot is full, pick the winner round-robin.
    - Load tx_data, set grant, set tx_start=1, clear the winner's slot, clear the timer, go to WAIT_BUSY.
    - Otherwise stay.
  - WAIT_BUSY:
    - tx_start=0; the timer increments each tick.
    - If tx_busy=1, go to WAIT_DONE.
    - Otherwise, when the timer reaches ACK_TIMEOUT, pulse tx_err and go to GAP. The byte is dropped, not retried.
  - WAIT_DONE: when tx_busy=0, increment sent_cnt and go to GAP.
  - GAP:
    - grant is cleared on entry.
    - Count GAP_TICKS, then go to IDLE.
- Round robin:
  - A pointer holds the highest-priority index.
  - After granting i, the pointer becomes (i+1) mod NREQ.
  - The pointer resets to 0.
  - The search order is pointer, pointer+1, … with wrap.
- tx_data holds its value from the issue edge until the next issue.
- Reset values:
  - req_ready all ones; slots empty.
  - tx_data 0x00, tx_start 0, grant 0, tx_err 0, sent_cnt 0, pointer 0.
  - State IDLE; timers 0.
- Reset mid-frame:
  - Everything returns to reset values immediately.
  - A byte in flight is abandoned; its sent_cnt increment is lost.
  - tx_busy is ignored until the state is IDLE again.

## Timing
- Latency: byte accepted at edge k, arbiter in IDLE, no competitors, so tx_start is high for the tick after edge k+1.
- tx_start is exactly one baudclk tick wide; it is never asserted outside the IDLE→WAIT_BUSY transition.
- tx_busy rising on the tick where the timer equals ACK_TIMEOUT counts as acknowledged: no tx_err.
- Frame-to-frame spacing: the next tx_start comes no earlier than GAP_TICKS+1 ticks after the edge that sees tx_busy fall.
- If tx_busy is already high when WAIT_BUSY is entered, the arbiter goes to WAIT_DONE on the first WAIT_BUSY tick.
- sent_cnt wraps 0xFFFF→0x0000 without a flag.

## Structure
- Package uart_pkg:
  - the state enum (IDLE, WAIT_BUSY, WAIT_DONE, GAP);
  - the byte width constant (8);
  - the counter width (16).
  - Both this block and the receiver/transmitter use it.
- Sub-module rr_pick: combinational round-robin priority selector.
  - Inputs: NREQ-bit request vector and pointer.
  - Outputs: one-hot grant and index.
- Everything else sits in the top module.

## Test plan
- Single request: req 1 sends 0x5A; tx_busy model high 2 ticks after start for 160 ticks. Expect tx_data=0x5A, grant=0010, one tx_start pulse, sent_cnt=1, req_ready[1] high again after issue.
- Contention: all four slots loaded on the same edge with 0x10..0x13. Expect issue order 0,1,2,3. Load again and expect 0,1,2,3 again, since the pointer is back at 0.
- Fairness: req 0 reloads continuously, req 2 loads once. Expect req 2 served no later than the second frame.
- Timeout: tx_busy held 0. Expect tx_err pulse ACK_TIMEOUT ticks after tx_start, no sent_cnt increment, the next slot served after GAP_TICKS.
- Reset mid-frame: assert reset during WAIT_DONE with two slots full. Expect immediate reset values, with req_ready=1111 and grant=0.
- Counter wrap: preload sent_cnt to 0xFFFF via a forced test, then complete one frame. Expect 0x0000.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte/counter widths and the TX arbiter state encoding.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester slots and transmitter handshake bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  import uart_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*BYTE_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic [BYTE_W-1:0]      tx_data;
  logic                   tx_start;
  logic                   tx_busy;
  logic [NREQ-1:0]        grant;
  logic                   tx_err;
  logic [CNT_W-1:0]       sent_cnt;

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_data, tx_start, grant, tx_err, sent_cnt
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_data, tx_start, grant, tx_err, sent_cnt
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, with wrap.
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  logic        found;
  int unsigned pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[IDX_W'(pos)]) begin
        found              = 1'b1;
        gnt[IDX_W'(pos)]   = 1'b1;
        idx                = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NREQ one-byte holding slots,
// with busy-ack timeout and an enforced inter-frame idle gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned GAP_TICKS   = 16,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input logic              baudclk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned IDX_W   = $clog2(NREQ);
  localparam int unsigned TMR_MAX = (GAP_TICKS > ACK_TIMEOUT) ? GAP_TICKS : ACK_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  arb_state_e        state;
  logic [NREQ-1:0]   ready_q;
  logic [BYTE_W-1:0] slot_data [NREQ];
  logic [IDX_W-1:0]  ptr;
  logic [TMR_W-1:0]  timer;
  logic [BYTE_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic [NREQ-1:0]   grant_q;
  logic              tx_err_q;
  logic [CNT_W-1:0]  sent_cnt_q;

  logic [NREQ-1:0]   slot_full;
  logic [NREQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]  pick_idx;

  assign slot_full = ~ready_q;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (slot_full),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Slot fill and issue never touch the same bit on one edge: fill needs empty, issue needs full.
  always_ff @(posedge baudclk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ready_q    <= '1;
      ptr        <= '0;
      timer      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      grant_q    <= '0;
      tx_err_q   <= 1'b0;
      sent_cnt_q <= '0;
      for (int unsigned i = 0; i < NREQ; i++) slot_data[i] <= '0;
    end else begin
      tx_start_q <= 1'b0;
      tx_err_q   <= 1'b0;

      for (int unsigned i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && ready_q[i]) begin
          slot_data[i] <= bus.req_data[i*BYTE_W +: BYTE_W];
          ready_q[i]   <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (|slot_full) begin
            tx_data_q         <= slot_data[pick_idx];
            grant_q           <= pick_gnt;
            tx_start_q        <= 1'b1;
            ready_q[pick_idx] <= 1'b1;
            timer             <= '0;
            ptr               <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            state             <= WAIT_BUSY;
          end
        end

        // A busy seen while timer == ACK_TIMEOUT still counts as acknowledged.
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (timer == TMR_W'(ACK_TIMEOUT)) begin
            tx_err_q <= 1'b1;
            grant_q  <= '0;
            timer    <= '0;
            state    <= GAP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            sent_cnt_q <= sent_cnt_q + CNT_W'(1);
            grant_q    <= '0;
            timer      <= '0;
            state      <= GAP;
          end
        end

        GAP: begin
          if (timer == TMR_W'(GAP_TICKS - 1)) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.grant     = grant_q;
  assign bus.tx_err    = tx_err_q;
  assign bus.sent_cnt  = sent_cnt_q;

endmodule
